// File: rtl/fetch_sequencer.sv
// Fetch-side sequencer: reads the PC, issues a single-beat imem read, holds the
// instruction for decode, then pulses a PC update with the sequential or redirect target.
module fetch_sequencer #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_INC  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               halt,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               upd_pc,
  output logic [ADDR_W-1:0]  pc_next
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StUpd} state_e;

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [ADDR_W-1:0]   pc_next_q, pc_next_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic                flush_q, flush_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      pc_next_q <= '0;
      tgt_q     <= '0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
      tgt_q     <= tgt_d;
      flush_q   <= flush_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    tgt_d     = tgt_q;
    flush_d   = flush_q;
    unique case (state_q)
      StIdle: begin
        // A redirect seen while idle is replayed through a discarded fetch.
        if (redirect) begin
          flush_d = 1'b1;
          tgt_d   = redirect_target;
        end
        if (!halt) state_d = StReq;
      end
      StReq: begin
        if (redirect) begin
          flush_d = 1'b1;
          tgt_d   = redirect_target;
        end
        state_d = StWait;
      end
      StWait: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          if (flush_q || redirect) begin
            // A same-cycle redirect is newer than any latched target.
            state_d   = StUpd;
            flush_d   = 1'b0;
            pc_next_d = redirect ? redirect_target : tgt_q;
          end else begin
            state_d = StHold;
          end
        end else if (redirect) begin
          flush_d = 1'b1;
          tgt_d   = redirect_target;
        end
      end
      StHold: begin
        if (redirect) begin
          state_d   = StUpd;
          flush_d   = 1'b0;
          pc_next_d = redirect_target;
        end else if (instr_ready) begin
          state_d   = StUpd;
          flush_d   = 1'b0;
          pc_next_d = pc + ADDR_W'(PC_INC);
        end
      end
      StUpd: begin
        state_d = halt ? StIdle : StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  assign imem_req    = (state_q == StReq);
  assign imem_addr   = imem_req ? pc : '0;
  assign instr       = instr_q;
  assign instr_valid = (state_q == StHold);
  assign upd_pc      = (state_q == StUpd);
  assign pc_next     = (upd_pc && redirect) ? redirect_target : pc_next_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer; the bench owns the PC register
// model and plays the instruction memory cycle by cycle.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        upd_pc;
  logic [31:0] pc_next;

  int checks   = 0;
  int failures = 0;
  int step_n   = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(32), .INSTR_W(32), .PC_INC(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .halt            (halt),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_valid      (imem_valid),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .upd_pc          (upd_pc),
    .pc_next         (pc_next)
  );

  // One clock cycle: inputs driven, expected outputs. 'all' forces instr/pc_next checks.
  typedef struct {
    logic        halt;
    logic        ival;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        ivld;
    logic [31:0] ins;
    logic        upd;
    logic [31:0] pn;
    logic        all;
  } vec_t;

  function automatic vec_t v(logic h, logic iv, logic [31:0] rd, logic rdy, logic rr,
                             logic [31:0] tg, logic rq, logic [31:0] ad, logic vl,
                             logic [31:0] in, logic up, logic [31:0] pn, logic al);
    vec_t r;
    r.halt = h;  r.ival = iv; r.rdata = rd; r.ready = rdy; r.redir = rr; r.tgt = tg;
    r.req  = rq; r.addr = ad; r.ivld  = vl; r.ins   = in;  r.upd   = up; r.pn  = pn;
    r.all  = al;
    return r;
  endfunction

  task automatic chk(string tag, string fld, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d %s: got 0x%08h want 0x%08h", tag, step_n, fld, act, exp);
    end
  endtask

  task automatic run(vec_t t, string tag);
    logic        upd_s;
    logic [31:0] pn_s;
    @(negedge clk);
    halt            = t.halt;
    imem_valid      = t.ival;
    imem_rdata      = t.rdata;
    instr_ready     = t.ready;
    redirect        = t.redir;
    redirect_target = t.tgt;
    #1;
    chk(tag, "imem_req", 32'(imem_req), 32'(t.req));
    chk(tag, "imem_addr", imem_addr, t.addr);
    chk(tag, "instr_valid", 32'(instr_valid), 32'(t.ivld));
    chk(tag, "upd_pc", 32'(upd_pc), 32'(t.upd));
    if (t.ivld || t.all) chk(tag, "instr", instr, t.ins);
    if (t.upd || t.all) chk(tag, "pc_next", pc_next, t.pn);
    upd_s = upd_pc;
    pn_s  = pc_next;
    @(posedge clk);
    #1;
    if (upd_s) pc = pn_s;
    step_n++;
  endtask

  task automatic do_reset(logic [31:0] pc0);
    @(negedge clk);
    reset = 1'b1;
    halt = 1'b0; imem_valid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_target = '0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    pc     = pc0;
    step_n = 0;
  endtask

  vec_t seq_tbl[14];

  initial begin
    reset = 1'b1; pc = '0; halt = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_target = '0;

    //            h iv rdata         rdy rr tgt  req addr vl ins           up pn al
    seq_tbl[0]  = v(0, 0, 32'h0,        1, 0, 0,  0, 0,   0, 32'h0,        0, 0, 1);
    seq_tbl[1]  = v(0, 0, 32'h0,        1, 0, 0,  1, 0,   0, 32'h0,        0, 0, 0);
    seq_tbl[2]  = v(0, 1, 32'hA000_0000, 1, 0, 0, 0, 0,   0, 32'h0,        0, 0, 0);
    seq_tbl[3]  = v(0, 0, 32'h0,        1, 0, 0,  0, 0,   1, 32'hA000_0000, 0, 0, 0);
    seq_tbl[4]  = v(0, 0, 32'h0,        1, 0, 0,  0, 0,   0, 32'h0,        1, 1, 0);
    seq_tbl[5]  = v(0, 0, 32'h0,        1, 0, 0,  1, 1,   0, 32'h0,        0, 0, 0);
    seq_tbl[6]  = v(0, 1, 32'hA000_0001, 1, 0, 0, 0, 0,   0, 32'h0,        0, 0, 0);
    seq_tbl[7]  = v(0, 0, 32'h0,        1, 0, 0,  0, 0,   1, 32'hA000_0001, 0, 0, 0);
    seq_tbl[8]  = v(0, 0, 32'h0,        1, 0, 0,  0, 0,   0, 32'h0,        1, 2, 0);
    seq_tbl[9]  = v(0, 0, 32'h0,        1, 0, 0,  1, 2,   0, 32'h0,        0, 0, 0);
    seq_tbl[10] = v(0, 1, 32'hA000_0002, 1, 0, 0, 0, 0,   0, 32'h0,        0, 0, 0);
    seq_tbl[11] = v(0, 0, 32'h0,        1, 0, 0,  0, 0,   1, 32'hA000_0002, 0, 0, 0);
    seq_tbl[12] = v(0, 0, 32'h0,        1, 0, 0,  0, 0,   0, 32'h0,        1, 3, 0);
    seq_tbl[13] = v(0, 0, 32'h0,        1, 0, 0,  1, 3,   0, 32'h0,        0, 0, 0);

    // Sequential fetch, 1-cycle memory
    do_reset(32'h0);
    for (int i = 0; i < 14; i++) run(seq_tbl[i], "seq");

    // Decode back-pressure: ready low for 5 HOLD cycles
    do_reset(32'h10);
    run(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "bp");
    run(v(0, 0, 0, 0, 0, 0, 1, 32'h10, 0, 0, 0, 0, 0), "bp");
    run(v(0, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "bp");
    for (int i = 0; i < 5; i++)
      run(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 0, 0, 0), "bp");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h1234_5678, 0, 0, 0), "bp");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h11, 0), "bp");
    run(v(0, 0, 0, 1, 0, 0, 1, 32'h11, 0, 0, 0, 0, 0), "bp");

    // Redirect in WAIT (latency 3), in HOLD racing ready, and during UPD
    do_reset(32'h20);
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "redir");
    run(v(0, 0, 0, 1, 0, 0, 1, 32'h20, 0, 0, 0, 0, 0), "redir");
    run(v(0, 0, 0, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0), "redir");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "redir");
    run(v(0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "redir");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0), "redir");
    run(v(0, 0, 0, 1, 0, 0, 1, 32'h40, 0, 0, 0, 0, 0), "redir");
    run(v(0, 1, 32'hB000_0040, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "redir");
    run(v(0, 0, 0, 1, 1, 32'h80, 0, 0, 1, 32'hB000_0040, 0, 0, 0), "redir");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0), "redir");
    run(v(0, 0, 0, 1, 0, 0, 1, 32'h80, 0, 0, 0, 0, 0), "redir");
    run(v(0, 1, 32'hB000_0080, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "redir");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'hB000_0080, 0, 0, 0), "redir");
    run(v(0, 0, 0, 1, 1, 32'h99, 0, 0, 0, 0, 1, 32'h99, 0), "redir");
    run(v(0, 0, 0, 1, 0, 0, 1, 32'h99, 0, 0, 0, 0, 0), "redir");

    // PC wrap at the top of the address space
    do_reset(32'hFFFF_FFFF);
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "wrap");
    run(v(0, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0), "wrap");
    run(v(0, 1, 32'h7777_0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "wrap");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h7777_0000, 0, 0, 0), "wrap");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0), "wrap");
    run(v(0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0), "wrap");

    // Reset while waiting on memory; late imem_valid must be ignored
    do_reset(32'h30);
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst");
    run(v(0, 0, 0, 1, 0, 0, 1, 32'h30, 0, 0, 0, 0, 0), "rst");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(v(0, 1, 32'hBAD0_0001, 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1), "rst");
    run(v(0, 1, 32'hBAD0_0002, 1, 0, 0, 1, 32'h30, 0, 0, 0, 0, 0), "rst");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst");
    run(v(0, 1, 32'h0000_0055, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h0000_0055, 0, 0, 0), "rst");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h31, 0), "rst");

    // Halt during UPD, plus a redirect latched while idle
    do_reset(32'h50);
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "halt");
    run(v(0, 0, 0, 1, 0, 0, 1, 32'h50, 0, 0, 0, 0, 0), "halt");
    run(v(0, 1, 32'hC000_0050, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "halt");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'hC000_0050, 0, 0, 0), "halt");
    run(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h51, 0), "halt");
    run(v(1, 0, 0, 1, 1, 32'h70, 0, 0, 0, 0, 0, 0, 0), "halt");
    run(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "halt");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "halt");
    run(v(0, 0, 0, 1, 0, 0, 1, 32'h51, 0, 0, 0, 0, 0), "halt");
    run(v(0, 1, 32'hC000_0051, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "halt");
    run(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h70, 0), "halt");
    run(v(0, 0, 0, 1, 0, 0, 1, 32'h70, 0, 0, 0, 0, 0), "halt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Fetch-side driver of the program counter register.
- Each instruction cycle it:
  - reads the current PC;
  - issues a single-beat read to instruction memory;
  - holds the returned instruction for decode under a valid/ready handshake;
  - commits the next PC, either sequential or a redirect target, by pulsing the PC's update-enable with the new value.
- Sits between the PC register, the instruction memory port and the decode stage.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- INSTR_W, 32, instruction word width.
- PC_INC, 1, sequential PC increment (word-addressed instruction memory).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- pc  in  ADDR_W  current PC value from the PC register
- halt  in  1  when high in IDLE or UPD, no new fetch is started
- imem_req  out  1  one-cycle read request strobe
- imem_addr  out  ADDR_W  read address, valid while imem_req=1
- imem_rdata  in  INSTR_W  read data
- imem_valid  in  1  read data valid, one cycle, at least 1 cycle after imem_req
- instr  out  INSTR_W  fetched instruction to decode
- instr_valid  out  1  instr is valid
- instr_ready  in  1  decode accepts instr
- redirect  in  1  branch/jump redirect strobe
- redirect_target  in  ADDR_W  redirect destination PC
- upd_pc  out  1  PC update enable, one-cycle pulse
- pc_next  out  ADDR_W  value for the PC to load when upd_pc=1

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: state=IDLE; imem_req=0, imem_addr=0, instr=0, instr_valid=0, upd_pc=0, pc_next=0; flush flag=0; latched target=0.
- Reset mid-operation: abandons any transaction. A late imem_valid arriving after reset is ignored.
- States and transitions:
  - IDLE: if !halt -> REQ.
  - REQ: imem_req=1, imem_addr=pc, for exactly one cycle -> WAIT.
  - WAIT: stay until imem_valid=1, then capture imem_rdata into instr.
    - If flush flag set or redirect=1 this cycle: discard instr -> UPD with target.
    - Else -> HOLD.
  - HOLD: instr_valid=1, instr stable.
    - redirect=1 (has priority over instr_ready): instr_valid drops, instruction dropped -> UPD with redirect_target.
    - Else instr_ready=1: handshake completes -> UPD with pc+PC_INC.
  - UPD: upd_pc=1 for one cycle; pc_next = selected value.
    - If redirect=1 during UPD, pc_next=redirect_target for that cycle (overrides).
    - Then -> REQ if !halt, else IDLE.
- Redirect handling:
  - A redirect in REQ or WAIT that is not consumed the same cycle sets the flush flag and latches redirect_target. A later redirect overwrites the latched target (last wins).
  - Flag clears on entry to UPD.
  - A redirect in IDLE is latched and applied via a REQ→WAIT→UPD pass with instruction discarded.
- imem_valid outside WAIT is ignored.
- Arithmetic: pc+PC_INC is modulo 2^ADDR_W; wraps to 0 at max address, no flag.
- PC timing: the PC register loads pc_next at the end of the UPD cycle, so the following REQ uses the new pc.
- Latency:
  - Memory latency L (L≥1) plus 0-cycle decode acceptance gives a minimum of 3+L cycles per instruction: REQ(1) + WAIT(L) + HOLD(1) + UPD(1).
  - With a 1-cycle memory, one instruction per 4 cycles.
- Outputs are registered except imem_addr (equals pc during REQ, 0 otherwise) and the UPD redirect override of pc_next.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, pc=0, memory latency 1, rdata=0xA000_0000+addr, instr_ready=1.
  - Required response: imem_addr 0,1,2 on successive REQs; instr 0xA000_0000, 0xA000_0001, 0xA000_0002; upd_pc pulses every 4 cycles with pc_next=1,2,3.
- Decode back-pressure:
  - Stimulus: instr_ready low for 5 cycles in HOLD.
  - Required response: instr_valid=1 and instr stable for all 5 cycles; no upd_pc; upd_pc the cycle after ready rises.
- Redirect timing:
  - Redirect=1, target=0x40 during WAIT with latency 3: returned instruction never presents instr_valid; pc_next=0x40; next imem_addr=0x40.
  - Redirect=1, target=0x80 in HOLD with instr_ready=1 same cycle: redirect wins, pc_next=0x80.
- Wrap: pc=0xFFFF_FFFF, normal fetch -> pc_next=0x0000_0000.
- Reset and halt:
  - Assert reset in WAIT, then deliver imem_valid 2 cycles later: outputs all 0, no instr_valid, no upd_pc, fresh REQ with imem_addr=pc.
  - halt=1 during UPD: returns to IDLE with imem_req=0 until halt deasserts, then REQ the next cycle.
